wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order pipeline write-back stream and a multi-cycle unit (e.g. the multiplier/divider) result stream.
- The pipeline write-back always has priority. Multi-cycle results wait in a small pending queue and drain into free write slots.
- Sits between the MEM/WB pipeline register outputs, the multi-cycle unit and the register file.
- Also reports pending destinations to decode for RAW/WAW stalls, and requests a pipeline bubble when queued results starve.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_pending_fifo.sv | 90 +++++++++
 rtl/wb_port_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Pending-entry layout, widths and the x0 address constant.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     data;
  } pend_entry_t;

  function automatic logic is_reg_zero(
    input logic [REG_ADDR_W-1:0] a
  );
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// Pending queue of multi-cycle results awaiting a free write slot.
// Ports: push/pop, head view, count, kill-by-dst and two dst match ports.
module wb_pending_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [REG_ADDR_W-1:0]          push_dst_i,
  input  logic [DATA_W-1:0]              push_data_i,
  input  logic                           pop_i,
  input  logic                           kill_i,
  input  logic [REG_ADDR_W-1:0]          kill_dst_i,
  input  logic [REG_ADDR_W-1:0]          qa_i,
  input  logic [REG_ADDR_W-1:0]          qb_i,
  output logic                           hit_a_o,
  output logic                           hit_b_o,
  output pend_entry_t                    head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  pend_entry_t      mem_q [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic do_push;
  logic do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Kill only touches entries already queued; the tail write
      // below lands after it, so a same-cycle push stays live.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && mem_q[i].live &&
            mem_q[i].dst == kill_dst_i) begin
          mem_q[i].live <= 1'b0;
        end
      end
      if (do_pop) begin
        mem_q[head_q].live <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      if (do_push) begin
        mem_q[tail_q] <= '{
          live: 1'b1,
          dst:  push_dst_i,
          data: push_data_i
        };
        tail_q <= tail_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Live bits are cleared on pop, so live implies occupied.
  always_comb begin
    hit_a_o = 1'b0;
    hit_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].live && mem_q[i].dst == qa_i) hit_a_o = 1'b1;
      if (mem_q[i].live && mem_q[i].dst == qb_i) hit_b_o = 1'b1;
    end
    if (is_reg_zero(qa_i)) hit_a_o = 1'b0;
    if (is_reg_zero(qb_i)) hit_b_o = 1'b0;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single RF write port: pipeline first, queued MC results after.
// Ports: pipe_* / mc_* in, rf_* out, pend_hit_* for decode, stall_req, occupancy.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pipe_wb_in,
  input  logic [DATA_W-1:0]           pipe_data_in,
  input  logic [REG_ADDR_W-1:0]       pipe_dst_in,
  input  logic                        mc_valid,
  input  logic [DATA_W-1:0]           mc_data,
  input  logic [REG_ADDR_W-1:0]       mc_dst,
  output logic                        mc_ready,
  output logic                        rf_we,
  output logic [REG_ADDR_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  input  logic [REG_ADDR_W-1:0]       query_a,
  input  logic [REG_ADDR_W-1:0]       query_b,
  output logic                        pend_hit_a,
  output logic                        pend_hit_b,
  output logic                        stall_req,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = $clog2(MAX_WAIT+1);

  logic                  pipe_grant;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count;
  pend_entry_t           head;

  logic                  rf_we_q,    rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic [WW-1:0]         wait_q,     wait_d;
  logic                  stall_q,    stall_d;

  assign pipe_grant = pipe_wb_in && !is_reg_zero(pipe_dst_in);
  assign mc_ready   = count < CW'(DEPTH);
  // x0 results complete the handshake but are never stored.
  assign push       = mc_valid && mc_ready && !is_reg_zero(mc_dst);
  assign pop        = !pipe_grant && (count != '0);

  wb_pending_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_dst_i  (mc_dst),
    .push_data_i (mc_data),
    .pop_i       (pop),
    .kill_i      (pipe_grant),
    .kill_dst_i  (pipe_dst_in),
    .qa_i        (query_a),
    .qb_i        (query_b),
    .hit_a_o     (pend_hit_a),
    .hit_b_o     (pend_hit_b),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (1'b1)
      pipe_grant: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = pipe_dst_in;
        rf_wdata_d = pipe_data_in;
      end
      (pop && head.live): begin
        rf_we_d    = 1'b1;
        rf_waddr_d = head.dst;
        rf_wdata_d = head.data;
      end
      default: ;
    endcase
  end

  // Counts cycles a non-empty queue loses the slot to the pipeline.
  always_comb begin
    wait_d = wait_q;
    if (pop || count == '0) begin
      wait_d = '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
    stall_d = (wait_d == WW'(MAX_WAIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wait_q     <= '0;
      stall_q    <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wait_q     <= wait_d;
      stall_q    <= stall_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign stall_req = stall_q;
  assign occupancy = count;

endmodule
